vector_batch_accumulator: RTL and testbench

- Sequential stage directly upstream of the vector/scalar divider in the training datapath.
- Sums a batch of ARR-typed vectors (one per accepted beat) element-wise and counts the accepted beats.
- Presents the sum vector and beat count together; the divider consumes them as vector1 and scalar to form the batch mean (e.g. averaged gradients/activations).
- Guarantees the count handed downstream is never 0.

---
 rtl/vector_batch_accumulator.sv | 140 ++++++++++++++
 tb/tb_vector_batch_accumulator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_batch_accumulator.sv
// Element-wise batch summer feeding the vector/scalar divider: sums one vector per
// accepted beat and counts beats. Define ACCUM_SATURATE_EN for saturating element adds.
`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

module vector_batch_accumulator #(
    parameter int NEURONS   = `MAX_NEURONS,
    parameter int DATA_W    = 32,
    parameter int BATCH_MAX = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               batch_size,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NEURONS*DATA_W-1:0] in_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NEURONS*DATA_W-1:0] sum_vec,
    output logic [31:0]               sum_count,
    output logic                      busy
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready; a result
    // transfers where out_valid && out_ready. Both readies/valids come from registered state.

    localparam int VW = NEURONS * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state;
    logic [31:0]               target;
    logic [31:0]               target_in;
    logic [31:0]               count_inc;
    logic [VW-1:0]             add_vec;
    logic signed [DATA_W-1:0]  el_a;
    logic signed [DATA_W-1:0]  el_b;
    logic signed [DATA_W-1:0]  el_s;
    logic                      accept;

    assign accept    = in_valid && in_ready;
    assign count_inc = sum_count + 32'd1;

    // Requested batch size is treated as a signed integer and clamped to 1..BATCH_MAX.
    always_comb begin
        target_in = batch_size;
        if ($signed(batch_size) < 32'sd1)
            target_in = 32'd1;
        else if ($signed(batch_size) > BATCH_MAX)
            target_in = 32'(BATCH_MAX);
    end

    always_comb begin
        add_vec = '0;
        el_a    = '0;
        el_b    = '0;
        el_s    = '0;
        for (int i = 0; i < NEURONS; i++) begin
            el_a = sum_vec[i*DATA_W +: DATA_W];
            el_b = in_vec[i*DATA_W +: DATA_W];
`ifdef ACCUM_SATURATE_EN
            el_s = el_a + el_b;
            // Same-sign operands producing an opposite-sign result means signed overflow.
            if ((el_a[DATA_W-1] == el_b[DATA_W-1]) && (el_s[DATA_W-1] != el_a[DATA_W-1]))
                el_s = el_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
`else
            el_s = el_a + el_b;
`endif
            add_vec[i*DATA_W +: DATA_W] = el_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            target    <= 32'd1;
            sum_vec   <= '0;
            sum_count <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target    <= target_in;
                        sum_vec   <= '0;
                        sum_count <= '0;
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sum_vec   <= add_vec;
                        sum_count <= count_inc;
                        if ((count_inc == target) || flush) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        in_ready <= 1'b0;
                        // An empty flush never presents a zero count downstream.
                        if (sum_count != 32'd0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_batch_accumulator.sv
// Bench for vector_batch_accumulator: table of batch scenarios, randomized batches
// against a per-batch arithmetic sum model, and hand sequences for corner cases.
module tb_vector_batch_accumulator;

    localparam int NEURONS = 4;
    localparam int DATA_W  = 32;
    localparam int VW      = NEURONS * DATA_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   batch_size;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] sum_vec;
    logic [31:0]   sum_count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    vector_batch_accumulator #(.NEURONS(NEURONS), .DATA_W(DATA_W), .BATCH_MAX(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .batch_size(batch_size), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
        .out_ready(out_ready), .sum_vec(sum_vec), .sum_count(sum_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bs;
        int offer;
        bit gaps;
        bit do_flush;
        int hold;
        int exp_count;
        bit exp_out;
    } scen_t;

    scen_t tbl[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int clamp_bs(input int bs);
        if (bs < 1) return 1;
        if (bs > 256) return 256;
        return bs;
    endfunction

    function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [VW-1:0] v;
        v = {d[31:0], c[31:0], b[31:0], a[31:0]};
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        int            e;
        for (int i = 0; i < NEURONS; i++) begin
            if ($urandom_range(0, 3) == 0) e = int'($urandom());
            else e = int'($urandom_range(0, 2000)) - 1000;
            v[i*32 +: 32] = e;
        end
        return v;
    endfunction

    // Reference: sum each element over the batch in wide arithmetic, then wrap or clamp.
    function automatic logic [VW-1:0] model_sum(input logic [VW-1:0] q[$]);
        longint        acc[NEURONS];
        logic [VW-1:0] v;
        logic [VW-1:0] r;
        logic [63:0]   t;
        for (int e = 0; e < NEURONS; e++) acc[e] = 0;
        for (int b = 0; b < q.size(); b++) begin
            v = q[b];
            for (int e = 0; e < NEURONS; e++) begin
                acc[e] = acc[e] + longint'($signed(v[e*32 +: 32]));
`ifdef ACCUM_SATURATE_EN
                if (acc[e] > 64'sd2147483647) acc[e] = 64'sd2147483647;
                if (acc[e] < -64'sd2147483648) acc[e] = -64'sd2147483648;
`else
                t = acc[e];
                acc[e] = longint'($signed(t[31:0]));
`endif
            end
        end
        r = '0;
        for (int e = 0; e < NEURONS; e++) begin
            t = acc[e];
            r[e*32 +: 32] = t[31:0];
        end
        return r;
    endfunction

    task automatic run_batch(input int bs, input int offer, input bit gaps, input bit do_flush,
                             input int hold, input int exp_count, input bit exp_out);
        int            target;
        int            n;
        int            sent;
        int            guard;
        logic [VW-1:0] vec;
        logic [VW-1:0] exp_v;
        logic [VW-1:0] q[$];
        target = clamp_bs(bs);
        n = (offer < target) ? offer : target;
        start = 1'b1;
        batch_size = bs;
        step();
        start = 1'b0;
        check("accum_busy", VW'(busy), VW'(1));
        check("accum_in_ready", VW'(in_ready), VW'(1));
        check("accum_count_clear", VW'(sum_count), VW'(0));
        sent = 0;
        guard = 0;
        while (sent < n && guard < 4000) begin
            guard++;
            check("beat_in_ready", VW'(in_ready), VW'(1));
            check("beat_out_valid_low", VW'(out_valid), VW'(0));
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                flush = 1'b0;
                in_vec = rand_vec();
            end else begin
                vec = rand_vec();
                in_vec = vec;
                in_valid = 1'b1;
                q.push_back(vec);
                sent++;
                flush = do_flush && (sent == n);
            end
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        if (sent < n) begin
            errors++;
            $display("FAIL beat_budget: sent %0d beats, required %0d", sent, n);
        end
        if (n == 0 && do_flush) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        if (exp_out) begin
            exp_v = model_sum(q);
            check("done_out_valid", VW'(out_valid), VW'(1));
            check("done_in_ready", VW'(in_ready), VW'(0));
            check("done_count", VW'(sum_count), VW'(exp_count));
            check("done_sum", sum_vec, exp_v);
            for (int h = 0; h < hold; h++) begin
                out_ready = 1'b0;
                start = 1'($urandom_range(0, 1));
                flush = 1'($urandom_range(0, 1));
                step();
                check("hold_out_valid", VW'(out_valid), VW'(1));
                check("hold_in_ready", VW'(in_ready), VW'(0));
                check("hold_count", VW'(sum_count), VW'(exp_count));
                check("hold_sum", sum_vec, exp_v);
            end
            flush = 1'b0;
            out_ready = 1'b1;
            start = 1'($urandom_range(0, 1));
            step();
            out_ready = 1'b0;
            start = 1'b0;
            check("idle_busy", VW'(busy), VW'(0));
            check("idle_out_valid", VW'(out_valid), VW'(0));
            check("idle_count_kept", VW'(sum_count), VW'(exp_count));
            check("idle_sum_kept", sum_vec, exp_v);
        end else begin
            check("noout_out_valid", VW'(out_valid), VW'(0));
            check("noout_busy", VW'(busy), VW'(0));
            check("noout_count", VW'(sum_count), VW'(exp_count));
        end
        step();
    endtask

    initial begin
        int            bs;
        int            tgt;
        int            offer;
        int            n;
        bit            fl;
        logic [VW-1:0] ovf;
        logic [VW-1:0] keep;

        tbl[0] = '{bs: 3,    offer: 3,   gaps: 0, do_flush: 0, hold: 0, exp_count: 3,   exp_out: 1};
        tbl[1] = '{bs: 2,    offer: 2,   gaps: 0, do_flush: 0, hold: 5, exp_count: 2,   exp_out: 1};
        tbl[2] = '{bs: 8,    offer: 3,   gaps: 0, do_flush: 1, hold: 0, exp_count: 3,   exp_out: 1};
        tbl[3] = '{bs: 8,    offer: 0,   gaps: 0, do_flush: 1, hold: 0, exp_count: 0,   exp_out: 0};
        tbl[4] = '{bs: 0,    offer: 1,   gaps: 0, do_flush: 0, hold: 0, exp_count: 1,   exp_out: 1};
        tbl[5] = '{bs: -5,   offer: 1,   gaps: 0, do_flush: 0, hold: 1, exp_count: 1,   exp_out: 1};
        tbl[6] = '{bs: 1000, offer: 256, gaps: 0, do_flush: 0, hold: 0, exp_count: 256, exp_out: 1};
        tbl[7] = '{bs: 6,    offer: 6,   gaps: 1, do_flush: 0, hold: 2, exp_count: 6,   exp_out: 1};
        tbl[8] = '{bs: 5,    offer: 5,   gaps: 1, do_flush: 1, hold: 0, exp_count: 5,   exp_out: 1};

        // Clock/reset
        rst_n = 1'b0;
        start = 1'b0;
        batch_size = '0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_vec = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_sum", sum_vec, '0);
        check("rst_count", VW'(sum_count), VW'(0));
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_in_ready", VW'(in_ready), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        rst_n = 1'b1;
        step();

        // Basic batch with fixed vectors and latency check
        start = 1'b1;
        batch_size = 3;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_vec = pack4(1, 2, 3, 4);
        step();
        in_vec = pack4(10, 20, 30, 40);
        step();
        check("basic_lat_out_valid", VW'(out_valid), VW'(0));
        in_vec = pack4(-1, -2, -3, -4);
        step();
        in_valid = 1'b0;
        check("basic_out_valid", VW'(out_valid), VW'(1));
        check("basic_sum", sum_vec, pack4(10, 20, 30, 40));
        check("basic_count", VW'(sum_count), VW'(3));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("basic_idle_busy", VW'(busy), VW'(0));

        // in_valid in IDLE is not accepted
        keep = sum_vec;
        in_valid = 1'b1;
        in_vec = pack4(7, 7, 7, 7);
        step();
        step();
        in_valid = 1'b0;
        check("idle_ignore_count", VW'(sum_count), VW'(3));
        check("idle_ignore_sum", sum_vec, keep);
        check("idle_ignore_ready", VW'(in_ready), VW'(0));

        // Table-driven scenarios
        for (int i = 0; i < 9; i++)
            run_batch(tbl[i].bs, tbl[i].offer, tbl[i].gaps, tbl[i].do_flush,
                      tbl[i].hold, tbl[i].exp_count, tbl[i].exp_out);

        // Overflow on element 0
        ovf = pack4(32'h7FFFFFFF, 0, 0, 0);
        start = 1'b1;
        batch_size = 2;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_vec = ovf;
        step();
        step();
        in_valid = 1'b0;
`ifdef ACCUM_SATURATE_EN
        check("ovf_elem0", VW'(sum_vec[31:0]), VW'(32'h7FFFFFFF));
`else
        check("ovf_elem0", VW'(sum_vec[31:0]), VW'(32'hFFFFFFFE));
`endif
        check("ovf_count", VW'(sum_count), VW'(2));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-batch, then a fresh batch starts from zero
        start = 1'b1;
        batch_size = 4;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_vec = pack4(9, 9, 9, 9);
        step();
        step();
        in_valid = 1'b0;
        check("mid_count", VW'(sum_count), VW'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum", sum_vec, '0);
        check("async_rst_count", VW'(sum_count), VW'(0));
        check("async_rst_busy", VW'(busy), VW'(0));
        check("async_rst_in_ready", VW'(in_ready), VW'(0));
        step();
        rst_n = 1'b1;
        step();
        run_batch(4, 4, 0, 0, 0, 4, 1);

        // Randomized batches
        for (int r = 0; r < 14; r++) begin
            bs = int'($urandom_range(0, 14)) - 2;
            tgt = clamp_bs(bs);
            fl = ($urandom_range(0, 2) == 0);
            offer = fl ? int'($urandom_range(0, tgt)) : tgt;
            n = (offer < tgt) ? offer : tgt;
            run_batch(bs, offer, 1'($urandom_range(0, 1)), fl, int'($urandom_range(0, 3)),
                      n, n > 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
